// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - handshake bundle between the reset sequencer and its reset domains
interface reset_sequencer_if #(
    parameter int NSTAGES = 3
);
    logic               sw_rst;
    logic [NSTAGES-1:0] stage_ack;
    logic [NSTAGES-1:0] out_rst;
    logic               done;
    logic               fault;
    logic [2:0]         state;

    modport master (
        input  sw_rst,
        input  stage_ack,
        output out_rst,
        output done,
        output fault,
        output state
    );

    modport slave (
        output sw_rst,
        output stage_ack,
        input  out_rst,
        input  done,
        input  fault,
        input  state
    );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered, ack-gated release of NSTAGES synchronous resets
// Optional ACK timeout with FAULT state: define RSTSEQ_ACK_TIMEOUT_EN.
module reset_sequencer #(
    parameter int NSTAGES        = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNTW           = 16
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.master  bus
);
    localparam int KW      = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES)
                           ? ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES)
                           : ((GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES);

    localparam logic [CNTW-1:0]    HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
    localparam logic [CNTW-1:0]    GAP_LAST  = CNTW'(GAP_CYCLES - 1);
    localparam logic [CNTW-1:0]    CNT_SAT   = CNTW'(CNT_MAX - 1);
    localparam logic [KW-1:0]      LAST_K    = KW'(NSTAGES - 1);
    localparam logic [NSTAGES-1:0] ONE       = NSTAGES'(1);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    localparam logic [CNTW-1:0]    TO_LAST   = CNTW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_HOLD  = 3'd0,
        S_GAP   = 3'd1,
        S_ACK   = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    logic [1:0]         sync_q;
    logic               rst_sync;
    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CNTW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [NSTAGES-1:0] out_rst_q, out_rst_d;

    // Async-set synchronizer: assertion is immediate, release is clocked in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst_sync = sync_q[1];
    assign cnt_inc  = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HOLD;
            k_q       <= '0;
            cnt_q     <= '0;
            out_rst_q <= '1;
        end else if (rst_sync) begin
            state_q   <= S_HOLD;
            k_q       <= '0;
            cnt_q     <= '0;
            out_rst_q <= '1;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            out_rst_q <= out_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        out_rst_d = out_rst_q;
        if (bus.sw_rst) begin
            state_d   = S_HOLD;
            k_d       = '0;
            cnt_d     = '0;
            out_rst_d = '1;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d   = S_ACK;
                        k_d       = '0;
                        cnt_d     = '0;
                        out_rst_d = out_rst_q & ~ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_ACK: begin
                    if (bus.stage_ack[k_q]) begin
                        cnt_d = '0;
                        if (k_q == LAST_K) begin
                            state_d   = S_DONE;
                            out_rst_d = '0;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
`ifdef RSTSEQ_ACK_TIMEOUT_EN
                        if (cnt_q == TO_LAST) begin
                            state_d   = S_FAULT;
                            out_rst_d = '1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
`endif
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d   = S_ACK;
                        k_d       = k_q + 1'b1;
                        cnt_d     = '0;
                        out_rst_d = out_rst_q & ~(ONE << (k_q + 1'b1));
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DONE: begin
                    out_rst_d = '0;
                    // A domain losing readiness restarts the whole sequence.
                    if (!(&bus.stage_ack)) begin
                        state_d   = S_HOLD;
                        k_d       = '0;
                        cnt_d     = '0;
                        out_rst_d = '1;
                    end
                end
                S_FAULT: begin
                    out_rst_d = '1;
                end
                default: begin
                    state_d   = S_HOLD;
                    k_d       = '0;
                    cnt_d     = '0;
                    out_rst_d = '1;
                end
            endcase
        end
    end

    assign bus.out_rst = out_rst_q;
    assign bus.done    = (state_q == S_DONE);
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    assign bus.fault   = (state_q == S_FAULT);
`else
    assign bus.fault   = 1'b0;
`endif
    assign bus.state   = state_q;
endmodule
